// File: rtl/change_dispenser_pkg.sv
// Shared coin definitions for the vending machine payout path: denomination
// indices, cent values and the dispenser state encoding.
package change_dispenser_pkg;

    localparam int unsigned NUM_DENOMS = 5;

    localparam logic [2:0] IDX_NICKEL  = 3'd0;
    localparam logic [2:0] IDX_DIME    = 3'd1;
    localparam logic [2:0] IDX_QUARTER = 3'd2;
    localparam logic [2:0] IDX_HALF    = 3'd3;
    localparam logic [2:0] IDX_DOLLAR  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_PULSE,
        ST_WAIT,
        ST_DONE,
        ST_FAULT
    } state_t;

    function automatic logic [12:0] coin_cents(input logic [2:0] idx);
        case (idx)
            IDX_NICKEL:  coin_cents = 13'd5;
            IDX_DIME:    coin_cents = 13'd10;
            IDX_QUARTER: coin_cents = 13'd25;
            IDX_HALF:    coin_cents = 13'd50;
            IDX_DOLLAR:  coin_cents = 13'd100;
            default:     coin_cents = 13'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_timer.sv
// dispense_timer: loadable down-counter that parks at zero; shared by the
// eject pulse width and the drop-sense timeout.
module dispense_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_en,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out latched change counts largest coin first, one
// hopper eject pulse at a time, confirming each coin on its drop sensor.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  nickel_in,
    input  logic [4:0]  dime_in,
    input  logic [4:0]  quarter_in,
    input  logic [4:0]  half_dollar_in,
    input  logic [4:0]  dollar_in,
    input  logic [4:0]  drop_sense,
    input  logic        clear,
    output logic [4:0]  eject,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [12:0] paid_cents
);

    localparam int unsigned TMR_MAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] PULSE_LOAD   = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_cur;
    logic [4:0]         r_count [NUM_DENOMS];
    logic [2:0]         w_sel_idx;
    logic               w_sel_any;
    logic               w_drop;
    logic [4:0]         w_cur_onehot;
    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_value;
    logic               w_tmr_en;
    logic               w_tmr_zero;
    logic [4:0]         r_eject;
    logic               r_busy;
    logic               r_done;
    logic               r_fault;
    logic [2:0]         r_fault_code;
    logic [12:0]        r_paid;

    dispense_timer #(.WIDTH(TMR_W)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_tmr_load),
        .i_load_value (w_tmr_value),
        .i_en         (w_tmr_en),
        .o_zero       (w_tmr_zero)
    );

    // Priority encoder: ascending scan, so the highest nonzero index wins.
    always_comb begin
        w_sel_idx = '0;
        w_sel_any = 1'b0;
        for (int unsigned i = 0; i < NUM_DENOMS; i++) begin
            if (r_count[i] != '0) begin
                w_sel_idx = 3'(i);
                w_sel_any = 1'b1;
            end
        end
    end

    assign w_drop       = ((r_state == ST_PULSE) || (r_state == ST_WAIT)) && drop_sense[r_cur];
    assign w_cur_onehot = 5'b00001 << r_cur;

    always_comb begin
        w_next      = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
        w_tmr_en    = 1'b0;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_SELECT;
            ST_SELECT: begin
                w_tmr_load  = 1'b1;
                w_tmr_value = PULSE_LOAD;
                w_next      = w_sel_any ? ST_PULSE : ST_DONE;
            end
            ST_PULSE: begin
                if (w_drop) begin
                    w_next = ST_SELECT;
                end else if (w_tmr_zero) begin
                    w_next      = ST_WAIT;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = TIMEOUT_LOAD;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_WAIT: begin
                if (w_drop)          w_next = ST_SELECT;
                else if (w_tmr_zero) w_next = ST_FAULT;
                else                 w_tmr_en = 1'b1;
            end
            ST_DONE:   w_next = ST_IDLE;
            ST_FAULT:  if (clear) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the current state, so each trails its state by one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cur        <= '0;
            r_eject      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= '0;
            r_paid       <= '0;
            for (int unsigned i = 0; i < NUM_DENOMS; i++) r_count[i] <= '0;
        end else begin
            r_state <= w_next;
            r_eject <= ((r_state == ST_PULSE) && !w_drop) ? w_cur_onehot : '0;
            r_busy  <= ((r_state == ST_IDLE) && start) || (r_state == ST_SELECT) ||
                       (r_state == ST_PULSE) || (r_state == ST_WAIT);
            r_done  <= (r_state == ST_DONE);
            r_fault <= (r_state == ST_FAULT) && !clear;
            if (r_state == ST_FAULT) r_fault_code <= r_cur;
            if ((r_state == ST_IDLE) && start) begin
                r_count[IDX_NICKEL]  <= nickel_in;
                r_count[IDX_DIME]    <= dime_in;
                r_count[IDX_QUARTER] <= quarter_in;
                r_count[IDX_HALF]    <= half_dollar_in;
                r_count[IDX_DOLLAR]  <= dollar_in;
                r_paid               <= '0;
            end
            if ((r_state == ST_SELECT) && w_sel_any) r_cur <= w_sel_idx;
            if (w_drop) begin
                r_count[r_cur] <= r_count[r_cur] - 5'd1;
                r_paid         <= r_paid + coin_cents(r_cur);
            end
        end
    end

    assign eject      = r_eject;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign paid_cents = r_paid;

endmodule
